// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: request handshake with operands,
// response handshake with result and flags, plus the busy indicator.
interface alu_seq_if #(
  parameter int DSIZE = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [DSIZE-1:0] a;
  logic [DSIZE-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [DSIZE-1:0] result;
  logic             zero;
  logic             busy;

  // Requester side: drives requests, consumes results
  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  // ALU side
  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ADD/SUB/AND/XOR/SLL/SRL/COM and a
// bit-serial shift-and-add multiply taking DSIZE cycles. One request in
// flight; results are held in DONE until the consumer takes them, and a
// new request may be accepted in the same cycle the result is taken.
module alu_seq #(
  parameter int DSIZE = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  localparam int CW = (DSIZE > 1) ? $clog2(DSIZE) : 1;
  localparam logic [CW-1:0]    CNT_LAST  = CW'(DSIZE - 1);
  localparam logic [DSIZE-1:0] SHIFT_LIM = DSIZE'(DSIZE);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SLL = 3'd4;
  localparam logic [2:0] OP_SRL = 3'd5;
  localparam logic [2:0] OP_COM = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  state_t           w_accept_state;

  logic [DSIZE-1:0] r_a;
  logic [DSIZE-1:0] r_b;
  logic [DSIZE-1:0] r_result;
  logic             r_zero;
  logic [CW-1:0]    r_cnt;
  logic [DSIZE-1:0] r_acc;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_mul_last;
  logic [DSIZE-1:0] w_alu;
  logic [DSIZE-1:0] w_partial;
  logic [DSIZE-1:0] w_acc_sum;

  assign w_in_ready = (r_state == S_IDLE) ||
                      ((r_state == S_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_mul_last = (r_cnt == CNT_LAST);

  // One multiply step: add the shifted multiplicand when this bit of b is set
  assign w_partial = r_b[r_cnt] ? (r_a << r_cnt) : '0;
  assign w_acc_sum = r_acc + w_partial;

  // Single-cycle operations computed straight from the request operands;
  // they are only registered on the accepting edge.
  always_comb begin
    w_alu = '0;
    case (bus.op)
      OP_ADD: w_alu = bus.a + bus.b;
      OP_SUB: w_alu = bus.a - bus.b;
      OP_AND: w_alu = bus.a & bus.b;
      OP_XOR: w_alu = bus.a ^ bus.b;
      OP_SLL: w_alu = (bus.b >= SHIFT_LIM) ? '0 : (bus.a << bus.b);
      OP_SRL: w_alu = (bus.b >= SHIFT_LIM) ? '0 : (bus.a >> bus.b);
      OP_COM: w_alu[0] = (bus.a <= bus.b);
      default: w_alu = '0;
    endcase
  end

  // Next-state logic; accepting from DONE behaves exactly like from IDLE
  always_comb begin
    w_accept_state = (bus.op == OP_MUL) ? S_MUL : S_DONE;
    w_state_next   = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = w_accept_state;
      end
      S_MUL: begin
        if (w_mul_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (w_accept)           w_state_next = w_accept_state;
        else if (bus.out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register; reset wins over any accept or multiply step
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Operand latch, result/zero registers and multiply accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
    end else if (w_accept) begin
      r_a    <= bus.a;
      r_b    <= bus.b;
      r_zero <= (bus.a == bus.b);
      r_cnt  <= '0;
      r_acc  <= '0;
      if (bus.op != OP_MUL) r_result <= w_alu;
    end else if (r_state == S_MUL) begin
      r_acc <= w_acc_sum;
      r_cnt <= r_cnt + 1'b1;
      if (w_mul_last) r_result <= w_acc_sum;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_MUL);
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at DSIZE = 8: a table of single requests with
// hand-computed results, then hand-written sequences for back-pressure,
// back-to-back accept, ignored requests during multiply and reset.
module tb_alu_seq;

  localparam int DSIZE = 8;

  logic clk;
  logic rst;

  alu_seq_if #(.DSIZE(DSIZE)) bus_if ();

  alu_seq #(.DSIZE(DSIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    int         edges;  // edges after the accepting edge until out_valid
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Wait for out_valid with a bound; returns edges waited and cycles seen busy
  task automatic wait_out(output int edges, output int busy_cnt, output logic rdy_ok);
    edges    = 0;
    busy_cnt = 0;
    rdy_ok   = 1'b1;
    while (bus_if.out_valid !== 1'b1 && edges < 100) begin
      if (bus_if.busy === 1'b1) busy_cnt++;
      if (bus_if.busy === 1'b1 && bus_if.in_ready !== 1'b0) rdy_ok = 1'b0;
      step();
      edges++;
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus_if.op       = op;
    bus_if.a        = a;
    bus_if.b        = b;
    bus_if.in_valid = 1'b1;
    step();
    bus_if.in_valid = 1'b0;
    // Scramble operands so a design that fails to latch them is caught
    bus_if.a  = 8'($urandom);
    bus_if.b  = 8'($urandom);
    bus_if.op = 3'($urandom);
  endtask

  task automatic consume();
    bus_if.out_ready = 1'b1;
    step();
    bus_if.out_ready = 1'b0;
  endtask

  initial begin
    int         edges;
    int         bcnt;
    logic       rdy_ok;
    logic [7:0] hold_res;
    logic       hold_z;

    //           op    a      b      res    z     edges
    vecs[0]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b0, 0};  // ADD wrap
    vecs[1]  = '{3'd1, 8'h03, 8'h05, 8'hFE, 1'b0, 0};  // SUB wrap
    vecs[2]  = '{3'd7, 8'd13, 8'd11, 8'h8F, 1'b0, 8};  // MUL 143
    vecs[3]  = '{3'd7, 8'hFF, 8'hFF, 8'h01, 1'b1, 8};  // MUL 0xFE01 low byte
    vecs[4]  = '{3'd6, 8'h05, 8'h05, 8'h01, 1'b1, 0};  // COM equal
    vecs[5]  = '{3'd6, 8'h06, 8'h05, 8'h00, 1'b0, 0};  // COM a > b
    vecs[6]  = '{3'd6, 8'h05, 8'hF0, 8'h01, 1'b0, 0};  // COM unsigned a < b
    vecs[7]  = '{3'd4, 8'h01, 8'd9,  8'h00, 1'b0, 0};  // SLL past width
    vecs[8]  = '{3'd4, 8'h03, 8'd2,  8'h0C, 1'b0, 0};  // SLL
    vecs[9]  = '{3'd5, 8'h80, 8'd7,  8'h01, 1'b0, 0};  // SRL
    vecs[10] = '{3'd5, 8'h80, 8'd8,  8'h00, 1'b0, 0};  // SRL exactly width
    vecs[11] = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 0};  // AND
    vecs[12] = '{3'd3, 8'hF0, 8'h3C, 8'hCC, 1'b0, 0};  // XOR
    vecs[13] = '{3'd7, 8'h07, 8'h00, 8'h00, 1'b0, 8};  // MUL by 0, full length
    vecs[14] = '{3'd0, 8'h80, 8'h80, 8'h00, 1'b1, 0};  // ADD, zero flag
    vecs[15] = '{3'd7, 8'h10, 8'h10, 8'h00, 1'b1, 8};  // MUL overflow to 0

    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.a         = '0;
    bus_if.b         = '0;
    bus_if.op        = '0;
    step();
    step();
    chk("reset out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("reset busy",      64'(bus_if.busy),      64'd0);
    chk("reset result",    64'(bus_if.result),    64'd0);
    chk("reset zero",      64'(bus_if.zero),      64'd0);
    rst = 1'b0;
    chk("reset in_ready",  64'(bus_if.in_ready),  64'd1);

    // Table-driven single requests
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_out(edges, bcnt, rdy_ok);
      $display("vec %0d op=%0d a=%02h b=%02h -> result=%02h zero=%0b edges=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, bus_if.result, bus_if.zero, edges);
      chk($sformatf("vec%0d latency", i),    64'(edges),            64'(vecs[i].edges));
      chk($sformatf("vec%0d busy cycles", i), 64'(bcnt),            64'(vecs[i].edges));
      chk($sformatf("vec%0d ready while busy", i), 64'(rdy_ok),     64'd1);
      chk($sformatf("vec%0d result", i),     64'(bus_if.result),    64'(vecs[i].res));
      chk($sformatf("vec%0d zero", i),       64'(bus_if.zero),      64'(vecs[i].z));
      consume();
      chk($sformatf("vec%0d idle after take", i), 64'(bus_if.out_valid), 64'd0);
    end

    // Requests presented during a multiply are dropped, not queued
    send(3'd7, 8'd13, 8'd11);
    bus_if.op       = 3'd0;
    bus_if.a        = 8'h01;
    bus_if.b        = 8'h01;
    bus_if.in_valid = 1'b1;
    step();
    step();
    step();
    bus_if.in_valid = 1'b0;
    wait_out(edges, bcnt, rdy_ok);
    $display("mul with ignored req -> result=%02h edges=%0d", bus_if.result, edges + 3);
    chk("ignored req latency", 64'(edges + 3),      64'd8);
    chk("ignored req result",  64'(bus_if.result),  64'h8F);
    consume();
    step();
    chk("no queued request",   64'(bus_if.out_valid), 64'd0);

    // Back-pressure hold, then back-to-back accept on the release cycle
    send(3'd0, 8'h01, 8'h02);
    wait_out(edges, bcnt, rdy_ok);
    hold_res = bus_if.result;
    hold_z   = bus_if.zero;
    chk("hold first result", 64'(hold_res), 64'h03);
    for (int k = 0; k < 3; k++) begin
      step();
      $display("hold cycle %0d: out_valid=%0b result=%02h in_ready=%0b",
               k, bus_if.out_valid, bus_if.result, bus_if.in_ready);
      chk($sformatf("hold%0d out_valid", k), 64'(bus_if.out_valid), 64'd1);
      chk($sformatf("hold%0d result", k),    64'(bus_if.result),    64'(hold_res));
      chk($sformatf("hold%0d zero", k),      64'(bus_if.zero),      64'(hold_z));
      chk($sformatf("hold%0d in_ready", k),  64'(bus_if.in_ready),  64'd0);
    end
    bus_if.out_ready = 1'b1;
    bus_if.op        = 3'd3;
    bus_if.a         = 8'hF0;
    bus_if.b         = 8'h3C;
    bus_if.in_valid  = 1'b1;
    #1;
    chk("b2b in_ready", 64'(bus_if.in_ready), 64'd1);
    step();
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    $display("back-to-back XOR -> out_valid=%0b result=%02h", bus_if.out_valid, bus_if.result);
    chk("b2b out_valid", 64'(bus_if.out_valid), 64'd1);
    chk("b2b result",    64'(bus_if.result),    64'hCC);
    consume();

    // Reset during the 4th multiply cycle abandons the multiply
    send(3'd7, 8'd13, 8'd11);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("reset mid-mul -> busy=%0b out_valid=%0b in_ready=%0b result=%02h",
             bus_if.busy, bus_if.out_valid, bus_if.in_ready, bus_if.result);
    chk("mid-mul rst busy",      64'(bus_if.busy),      64'd0);
    chk("mid-mul rst out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("mid-mul rst in_ready",  64'(bus_if.in_ready),  64'd1);
    chk("mid-mul rst result",    64'(bus_if.result),    64'h00);

    // in_valid together with reset is not accepted
    bus_if.op       = 3'd0;
    bus_if.a        = 8'h11;
    bus_if.b        = 8'h22;
    bus_if.in_valid = 1'b1;
    rst             = 1'b1;
    step();
    rst             = 1'b0;
    bus_if.in_valid = 1'b0;
    step();
    $display("req during reset -> out_valid=%0b result=%02h", bus_if.out_valid, bus_if.result);
    chk("rst+valid out_valid", 64'(bus_if.out_valid), 64'd0);
    chk("rst+valid result",    64'(bus_if.result),    64'h00);

    // Fresh request after reset
    send(3'd2, 8'hF0, 8'h3C);
    wait_out(edges, bcnt, rdy_ok);
    $display("AND after reset -> result=%02h edges=%0d", bus_if.result, edges);
    chk("post-rst AND latency", 64'(edges),         64'd0);
    chk("post-rst AND result",  64'(bus_if.result), 64'h30);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter DSIZE, default 32, meaning operand/result width in bits (legal range 4..64).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port a  input  DSIZE  first operand.
REQ-007 SHALL have port b  input  DSIZE  second operand.
REQ-008 SHALL have port op  input  3  operation: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 SLL, 5 SRL, 6 COM, 7 MUL.
REQ-009 SHALL have port out_valid  output  1  result/zero valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port result  output  DSIZE  registered result.
REQ-012 SHALL have port zero  output  1  registered flag, 1 when the request's a == b.
REQ-013 SHALL have port busy  output  1  high while a multiply is iterating.

Function
REQ-014 SHALL implement states IDLE, MUL, DONE; busy = (state == MUL).
REQ-015 SHALL drive in_ready = (state == IDLE) or (state == DONE and out_ready); accept = in_valid and in_ready.
REQ-016 SHALL latch a, b, op and compute zero from the latched a == b on accept; later input changes have no effect on that request.
REQ-017 Non-MUL accept SHALL register the result and go to DONE: out_valid high the cycle after the accepting edge (latency 1).
REQ-018 ADD/SUB SHALL be modulo 2^DSIZE; AND/XOR bitwise; COM SHALL give 1 zero-extended when a <= b unsigned, else 0.
REQ-019 SLL/SRL SHALL shift logically by the full unsigned value of b; shift >= DSIZE SHALL give 0.
REQ-020 MUL accept SHALL go to MUL with bit counter 0 and accumulator 0; each MUL cycle SHALL add (a << i) when b[i] = 1, i = counter, then increment the counter.
REQ-021 MUL SHALL last exactly DSIZE cycles; the edge processing bit DSIZE-1 SHALL go to DONE, so out_valid rises DSIZE cycles after the accepting edge.
REQ-022 MUL result SHALL be the low DSIZE bits of the unsigned product; no early termination when b has zero high bits.
REQ-023 in_valid during MUL SHALL be ignored (in_ready = 0), with no request lost or queued.
REQ-024 In DONE, out_valid, result and zero SHALL hold stable while out_ready = 0.
REQ-025 In DONE with out_ready = 1: if in_valid = 1, the new request SHALL be accepted in the same cycle (back-to-back, no bubble); else go to IDLE with out_valid = 0.
REQ-026 out_valid SHALL be 0 in IDLE and MUL.

Reset
REQ-027 rst = 1 at a rising edge SHALL force IDLE, out_valid 0, busy 0, result 0, zero 0, counter 0, accumulator 0; in_ready = 1 on the following cycle.
REQ-028 rst SHALL take priority over accept and over MUL iteration; a multiply in progress SHALL be abandoned with no output.
REQ-029 in_valid asserted in the same cycle as rst SHALL NOT be accepted.

Verification (DSIZE = 8)
REQ-030 ADD a=0xFF b=0x01 -> one cycle later out_valid=1, result=0x00, zero=0; SUB a=0x03 b=0x05 -> result=0xFE.
REQ-031 MUL a=13 b=11 -> busy=1 and in_ready=0 for 8 cycles; out_valid rises exactly 8 cycles after accept; result=0x8F.
REQ-032 MUL a=0xFF b=0xFF -> result=0x01; COM a=5 b=5 -> result=0x01, zero=1; SLL a=0x01 b=9 -> 0x00; SRL a=0x80 b=7 -> 0x01.
REQ-033 Hold out_ready=0 for 3 cycles after result -> result/zero/out_valid stable, in_ready=0; then out_ready=1 with in_valid=1 (XOR 0xF0,0x3C) -> accepted that edge, next cycle result=0xCC.
REQ-034 Assert rst during the 4th MUL cycle -> next cycle busy=0, out_valid=0, in_ready=1, result=0x00; a fresh AND 0xF0,0x3C then gives 0x30 at latency 1.
